// File: rtl/ddr2_multibit_tap_ctrl.sv
// DDR2 read-capture IDELAY calibration: walks each DQ bit's tap chain looking for data
// transitions, then parks the tap at a quarter-period offset (MODE 0) or window centre (MODE 1).
module ddr2_multibit_tap_ctrl #(
    parameter int NUM_BITS      = 8,
    parameter int TAP_W         = 6,
    parameter int MAX_TAP_COUNT = 31,
    parameter int SETTLE_CYC    = 8,
    parameter int MODE          = 0,
    localparam int SEL_W        = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BITS-1:0] dq_data,
    input  logic                ctrl_dummyread_start,
    output logic [NUM_BITS-1:0] dlyce,
    output logic                dlyinc,
    output logic [SEL_W-1:0]    bit_sel,
    output logic [TAP_W-1:0]    tap_val,
    output logic [NUM_BITS-1:0] bit_err,
    output logic                chan_done
);

    localparam logic [TAP_W-1:0] TMAX  = '1;
    localparam logic [TAP_W-1:0] MAXC  = TAP_W'(MAX_TAP_COUNT);
    localparam int               CNT_W = $clog2(SETTLE_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, BIT_INIT, INC, SETTLE, EDGE, MOVE_INC, MOVE_DEC, BIT_DONE, ALL_DONE
    } state_t;

    state_t            state, next_state, edge_next;
    logic              calib_start;
    logic              prev_dq, edge_hit, e1_valid;
    logic [TAP_W-1:0]  e1, move_cnt, edge_cnt;
    logic [TAP_W:0]    span_plus1;
    logic [CNT_W-1:0]  settle_cnt;
    logic              edge_err, edge_rec;
    logic              cur_dq, last_bit;

    assign cur_dq   = dq_data[bit_sel];
    assign last_bit = (bit_sel == SEL_W'(NUM_BITS - 1));
    assign span_plus1 = {1'b0, tap_val - e1} + 1'b1;

    // Park point when only one edge exists: a quarter period away, toward the middle of the chain.
    function automatic logic [TAP_W-1:0] single_target(input logic [TAP_W-1:0] e);
        return (e > MAXC) ? e - MAXC : e + MAXC;
    endfunction

    always_comb begin
        edge_next = INC;
        edge_cnt  = '0;
        edge_err  = 1'b0;
        edge_rec  = 1'b0;
        if (edge_hit) begin
            if (MODE == 0) begin
                edge_cnt  = MAXC;
                edge_next = (tap_val > MAXC) ? MOVE_DEC : MOVE_INC;
            end else if (e1_valid) begin
                edge_cnt  = span_plus1[TAP_W:1];
                edge_next = MOVE_DEC;
            end else if (tap_val == TMAX) begin
                edge_cnt  = TMAX - single_target(tap_val);
                edge_next = MOVE_DEC;
            end else begin
                edge_rec  = 1'b1;
            end
        end else if (tap_val == TMAX) begin
            edge_next = MOVE_DEC;
            if (MODE != 0 && e1_valid) begin
                edge_cnt = TMAX - single_target(e1);
            end else begin
                edge_cnt = MAXC;
                edge_err = 1'b1;
            end
        end
        if ((edge_next == MOVE_INC || edge_next == MOVE_DEC) && edge_cnt == '0)
            edge_next = BIT_DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (calib_start) next_state = BIT_INIT;
            BIT_INIT: next_state = INC;
            INC:      next_state = SETTLE;
            SETTLE:   if (settle_cnt == SETTLE_LAST) next_state = EDGE;
            EDGE:     next_state = edge_next;
            MOVE_INC,
            MOVE_DEC: if (move_cnt <= TAP_W'(1)) next_state = BIT_DONE;
            BIT_DONE: next_state = last_bit ? ALL_DONE : BIT_INIT;
            ALL_DONE: next_state = ALL_DONE;
            default:  next_state = IDLE;
        endcase
        if (!ctrl_dummyread_start) next_state = IDLE;
    end

    // Tap counter saturates so a misbehaving move can never wrap the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            calib_start <= 1'b0;
            bit_sel     <= '0;
            tap_val     <= '0;
            prev_dq     <= 1'b0;
            edge_hit    <= 1'b0;
            e1          <= '0;
            e1_valid    <= 1'b0;
            move_cnt    <= '0;
            settle_cnt  <= '0;
            bit_err     <= '0;
        end else begin
            calib_start <= ctrl_dummyread_start;
            if (!ctrl_dummyread_start) begin
                bit_sel <= '0;
            end else begin
                case (state)
                    IDLE: if (calib_start) begin
                        bit_err <= '0;
                        bit_sel <= '0;
                    end
                    BIT_INIT: begin
                        tap_val  <= '0;
                        e1       <= '0;
                        e1_valid <= 1'b0;
                        edge_hit <= 1'b0;
                        move_cnt <= '0;
                        prev_dq  <= cur_dq;
                    end
                    INC: begin
                        if (tap_val != TMAX) tap_val <= tap_val + 1'b1;
                        settle_cnt <= '0;
                    end
                    SETTLE: begin
                        settle_cnt <= settle_cnt + 1'b1;
                        if (settle_cnt == SETTLE_LAST) begin
                            edge_hit <= (cur_dq != prev_dq);
                            prev_dq  <= cur_dq;
                        end
                    end
                    EDGE: begin
                        move_cnt <= edge_cnt;
                        edge_hit <= 1'b0;
                        if (edge_rec) begin
                            e1       <= tap_val;
                            e1_valid <= 1'b1;
                        end
                        if (edge_err) bit_err[bit_sel] <= 1'b1;
                    end
                    MOVE_INC: begin
                        if (tap_val != TMAX) tap_val <= tap_val + 1'b1;
                        move_cnt <= move_cnt - 1'b1;
                    end
                    MOVE_DEC: begin
                        if (tap_val != '0) tap_val <= tap_val - 1'b1;
                        move_cnt <= move_cnt - 1'b1;
                    end
                    BIT_DONE: if (!last_bit) bit_sel <= bit_sel + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        dlyce     = '0;
        dlyinc    = 1'b0;
        chan_done = 1'b0;
        case (state)
            INC, MOVE_INC: begin
                dlyce[bit_sel] = 1'b1;
                dlyinc         = 1'b1;
            end
            MOVE_DEC: dlyce[bit_sel] = 1'b1;
            ALL_DONE: chan_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ddr2_multibit_tap_ctrl.sv
// Bench for ddr2_multibit_tap_ctrl: one MODE 0 and one MODE 1 instance drive an IDELAY/data-eye
// model whose dq toggles at chosen taps; results are compared with a rule-level calibration model.
module tb_ddr2_multibit_tap_ctrl;

    typedef struct {
        int mode;
        int ea0, eb0, ea1, eb1;
        int glitch;
        int fin0, inc0, dec0;
        int fin1, inc1, dec1;
        int err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_w  [2];
    logic [1:0] dq_w     [2];
    logic [1:0] dlyce_w  [2];
    logic       dlyinc_w [2];
    logic       bit_sel_w[2];
    logic [5:0] tap_w    [2];
    logic [1:0] err_w    [2];
    logic       done_w   [2];

    int btap[2][2], incs[2][2], decs[2][2];
    int edge_a[2][2], edge_b[2][2];
    int since_inc[2];
    int glitch_tap;
    int clr_req = 0, clr_ack = 0;
    int n_err = 0, n_chk = 0;
    vec_t tbl[8];

    always #5 clk = ~clk;

    ddr2_multibit_tap_ctrl #(.NUM_BITS(2), .TAP_W(6), .MAX_TAP_COUNT(31), .SETTLE_CYC(8), .MODE(0)) dut0 (
        .clk(clk), .reset(reset), .dq_data(dq_w[0]), .ctrl_dummyread_start(start_w[0]),
        .dlyce(dlyce_w[0]), .dlyinc(dlyinc_w[0]), .bit_sel(bit_sel_w[0]), .tap_val(tap_w[0]),
        .bit_err(err_w[0]), .chan_done(done_w[0]));

    ddr2_multibit_tap_ctrl #(.NUM_BITS(2), .TAP_W(6), .MAX_TAP_COUNT(31), .SETTLE_CYC(8), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .dq_data(dq_w[1]), .ctrl_dummyread_start(start_w[1]),
        .dlyce(dlyce_w[1]), .dlyinc(dlyinc_w[1]), .bit_sel(bit_sel_w[1]), .tap_val(tap_w[1]),
        .bit_err(err_w[1]), .chan_done(done_w[1]));

    // IDELAY chain plus data eye: each dlyce pulse moves that bit's tap, and dq flips at every edge tap.
    always @(negedge clk) begin
        logic v;
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 2; b++) begin
                if (clr_req != clr_ack) begin
                    btap[d][b] = 0; incs[d][b] = 0; decs[d][b] = 0;
                end else if (dlyce_w[d][b]) begin
                    if (dlyinc_w[d]) begin
                        incs[d][b]++;
                        if (btap[d][b] < 63) btap[d][b]++;
                    end else begin
                        decs[d][b]++;
                        if (btap[d][b] > 0) btap[d][b]--;
                    end
                end
            end
            since_inc[d] = (dlyce_w[d] != 2'b00 && dlyinc_w[d]) ? 0 :
                           (since_inc[d] < 100 ? since_inc[d] + 1 : 100);
        end
        clr_ack = clr_req;
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 2; b++) begin
                v = ((edge_a[d][b] != 0) && (btap[d][b] >= edge_a[d][b])) ^
                    ((edge_b[d][b] != 0) && (btap[d][b] >= edge_b[d][b]));
                if (d == 0 && b == 0 && glitch_tap != 0 && btap[0][0] == glitch_tap &&
                    since_inc[0] >= 3 && since_inc[0] <= 5)
                    v = ~v;
                dq_w[d][b] = v;
            end
        end
    end

    // Calibration outcome for one bit, straight from the edge positions.
    function automatic void model(input int mode, input int ea, input int eb,
                                  output int fin, output int inc, output int dec, output int err);
        int tgt;
        err = 0;
        if (ea == 0) begin
            inc = 63; dec = 31; fin = 32; err = 1;
        end else if (mode == 0) begin
            inc = (ea <= 31) ? ea + 31 : ea;
            dec = (ea > 31) ? 31 : 0;
            fin = (ea > 31) ? ea - 31 : ea + 31;
        end else if (eb != 0) begin
            inc = eb;
            dec = (eb - ea + 1) / 2;
            fin = eb - dec;
        end else begin
            tgt = (ea > 31) ? ea - 31 : ea + 31;
            inc = 63; dec = 63 - tgt; fin = tgt;
        end
    endfunction

    function automatic vec_t build_vec(input int mode, input int ea0, input int eb0,
                                       input int ea1, input int eb1);
        vec_t v;
        int e0, e1;
        v.mode = mode; v.ea0 = ea0; v.eb0 = eb0; v.ea1 = ea1; v.eb1 = eb1; v.glitch = 0;
        model(mode, ea0, eb0, v.fin0, v.inc0, v.dec0, e0);
        model(mode, ea1, eb1, v.fin1, v.inc1, v.dec1, e1);
        v.err = e0 | (e1 << 1);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_edges(input vec_t v);
        edge_a[v.mode][0] = v.ea0; edge_b[v.mode][0] = v.eb0;
        edge_a[v.mode][1] = v.ea1; edge_b[v.mode][1] = v.eb1;
        glitch_tap = v.glitch;
    endtask

    task automatic restart(input int d);
        start_w[d] = 1'b0;
        clr_req++;
        repeat (3) @(negedge clk);
        start_w[d] = 1'b1;
    endtask

    task automatic apply_stimulus(input string tag, input vec_t v);
        int waited;
        set_edges(v);
        restart(v.mode);
        waited = 0;
        while (!done_w[v.mode] && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_chan_done"}, int'(done_w[v.mode]), 1);
    endtask

    task automatic check_output(input string tag, input vec_t v);
        int d;
        d = v.mode;
        check({tag, "_fin0"}, btap[d][0], v.fin0);
        check({tag, "_inc0"}, incs[d][0], v.inc0);
        check({tag, "_dec0"}, decs[d][0], v.dec0);
        check({tag, "_fin1"}, btap[d][1], v.fin1);
        check({tag, "_inc1"}, incs[d][1], v.inc1);
        check({tag, "_dec1"}, decs[d][1], v.dec1);
        check({tag, "_bit_err"}, int'(err_w[d]), v.err);
        check({tag, "_tap_val"}, int'(tap_w[d]), v.fin1);
        start_w[d] = 1'b0;
        glitch_tap = 0;
        @(negedge clk);
        check({tag, "_done_drop"}, int'(done_w[d]), 0);
    endtask

    initial begin
        vec_t v;
        int waited, ea, eb, ea1, eb1, mode;

        tbl[0] = '{0, 10, 0, 40, 0, 0, 41, 41, 0, 9, 40, 31, 0};
        tbl[1] = '{0, 0, 0, 5, 0, 0, 32, 63, 31, 36, 36, 0, 1};
        tbl[2] = '{1, 10, 31, 10, 30, 0, 20, 31, 11, 20, 30, 10, 0};
        tbl[3] = '{1, 20, 0, 0, 0, 0, 51, 63, 12, 32, 63, 31, 2};
        tbl[4] = '{1, 40, 0, 62, 63, 0, 9, 63, 54, 62, 63, 1, 0};
        tbl[5] = '{0, 31, 0, 32, 0, 0, 62, 62, 0, 1, 32, 31, 0};
        tbl[6] = '{1, 63, 0, 1, 2, 0, 32, 63, 31, 1, 2, 1, 0};
        tbl[7] = '{0, 20, 0, 3, 0, 5, 51, 51, 0, 34, 34, 0, 0};

        reset = 1'b1;
        glitch_tap = 0;
        for (int d = 0; d < 2; d++) begin
            start_w[d] = 1'b0;
            for (int b = 0; b < 2; b++) begin
                edge_a[d][b] = 0; edge_b[d][b] = 0;
            end
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst%0d_dlyce", d), int'(dlyce_w[d]), 0);
            check($sformatf("rst%0d_dlyinc", d), int'(dlyinc_w[d]), 0);
            check($sformatf("rst%0d_tap", d), int'(tap_w[d]), 0);
            check($sformatf("rst%0d_err", d), int'(err_w[d]), 0);
            check($sformatf("rst%0d_done", d), int'(done_w[d]), 0);
            check($sformatf("rst%0d_bit_sel", d), int'(bit_sel_w[d]), 0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus($sformatf("vec%0d", i), tbl[i]);
            check_output($sformatf("vec%0d", i), tbl[i]);
        end

        // Dropping the dummy-read request mid-search must abandon the pass and restart at bit 0.
        v = build_vec(0, 5, 0, 0, 0);
        set_edges(v);
        restart(0);
        waited = 0;
        while (bit_sel_w[0] !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("abort_reach_bit1", int'(bit_sel_w[0]), 1);
        repeat (20) @(negedge clk);
        start_w[0] = 1'b0;
        @(posedge clk);
        #1;
        check("abort_bit_sel", int'(bit_sel_w[0]), 0);
        check("abort_dlyce", int'(dlyce_w[0]), 0);
        check("abort_done", int'(done_w[0]), 0);
        apply_stimulus("abort_rerun", v);
        check_output("abort_rerun", v);

        // Asynchronous reset landing in the middle of a decrement walk.
        v = build_vec(0, 0, 0, 0, 0);
        set_edges(v);
        restart(0);
        waited = 0;
        while (!(dlyce_w[0][0] === 1'b1 && dlyinc_w[0] === 1'b0) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("rstmove_in_dec", int'(dlyce_w[0][0] === 1'b1 && dlyinc_w[0] === 1'b0), 1);
        check("rstmove_err_before", int'(err_w[0]), 1);
        #2 reset = 1'b1;
        #1;
        check("rstmove_dlyce", int'(dlyce_w[0]), 0);
        check("rstmove_tap", int'(tap_w[0]), 0);
        check("rstmove_err", int'(err_w[0]), 0);
        check("rstmove_done", int'(done_w[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        start_w[0] = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 10; r++) begin
            mode = int'($urandom_range(0, 1));
            ea  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 63));
            eb  = (ea != 0 && ea < 63 && $urandom_range(0, 1) == 1) ? int'($urandom_range(ea + 1, 63)) : 0;
            ea1 = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 63));
            eb1 = (ea1 != 0 && ea1 < 63 && $urandom_range(0, 1) == 1) ? int'($urandom_range(ea1 + 1, 63)) : 0;
            v = build_vec(mode, ea, eb, ea1, eb1);
            apply_stimulus($sformatf("rnd%0d", r), v);
            check_output($sformatf("rnd%0d", r), v);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
